fft_frame_ctrl: RTL and testbench

//  Frame sequencer for the 16-lane FFT pipeline (step0_0 -> step0_1 -> step0_2 -> module0_cbfp).
//  - Input side: accepts source beats (one beat = 16 complex samples) and issues a contiguous

---
 rtl/fft_frame_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_fft_frame_ctrl.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_frame_ctrl.sv
// fft_frame_ctrl: frame sequencer for the 16-lane FFT pipeline.
//   Input side issues one contiguous FRAME_BEATS-beat burst per frame into
//   step0_0. Output side counts cbfp beats to retire frames and bounds the
//   number of frames in flight. Adds an inter-frame gap, a flush/drain path
//   and sticky error flags.
//
// Handshake: a source beat transfers on a rising edge where
//   src_valid & src_ready are both high. src_ready depends only on
//   registered state and on en/flush, never on src_valid, so the source may
//   wait on src_ready before raising src_valid without a combinational loop.
//   fft_valid/beat_idx/frame_start follow the transfer by exactly one cycle,
//   matching the data register in the parent that loads on the same
//   transfer. pipe_out_valid has no back-pressure: every high cycle is one
//   cbfp output beat.
module fft_frame_ctrl #(
  parameter int FRAME_BEATS  = 32,
  parameter int CNT_W        = 5,
  parameter int MAX_INFLIGHT = 4,
  parameter int IF_W         = 3,
  parameter int GAP_CYCLES   = 2
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            en,
  input  logic            flush,
  input  logic            clr_err,
  input  logic            src_valid,
  output logic            src_ready,
  output logic            fft_valid,
  output logic [CNT_W-1:0] beat_idx,
  output logic            frame_start,
  input  logic            pipe_out_valid,
  output logic            frame_done,
  output logic [IF_W-1:0] inflight,
  output logic            busy,
  output logic            flush_done,
  output logic            err_underrun,
  output logic            err_overflow,
  output logic [1:0]      fsm_state
);

  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(FRAME_BEATS - 1);
  localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(GAP_CYCLES - 1);
  localparam logic [IF_W-1:0]  MAX_IF    = IF_W'(MAX_INFLIGHT);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_GAP   = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t           state;
  logic             armed;
  logic [CNT_W-1:0] beat_cnt;
  logic [CNT_W-1:0] out_cnt;
  logic [GAP_W-1:0] gap_cnt;

  logic accept;
  logic start;
  logic out_beat;
  logic out_last;
  logic underrun_evt;
  logic overflow_evt;

  // armed keeps src_ready low while rstn is asserted, even with en high
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) armed <= 1'b0;
    else       armed <= 1'b1;
  end

  // Ready generation: open in IDLE only when a frame slot is free, always open in RUN
  always_comb begin
    src_ready = 1'b0;
    unique case (state)
      S_IDLE:  src_ready = armed & en & ~flush & (inflight < MAX_IF);
      S_RUN:   src_ready = 1'b1;
      default: src_ready = 1'b0;
    endcase
  end

  assign accept       = src_valid & src_ready;
  assign start        = accept & (state == S_IDLE);
  assign out_beat     = pipe_out_valid & (inflight != '0);
  assign out_last     = out_beat & (out_cnt == LAST_BEAT);
  assign overflow_evt = pipe_out_valid & (inflight == '0);
  assign underrun_evt = (state == S_RUN) & ~src_valid;
  assign busy         = (state != S_IDLE) | (inflight != '0);
  assign fsm_state    = state;

  // Input-side sequencer: frame burst, gap, drain, with registered issue outputs
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= S_IDLE;
      beat_cnt    <= '0;
      gap_cnt     <= '0;
      fft_valid   <= 1'b0;
      beat_idx    <= '0;
      frame_start <= 1'b0;
      flush_done  <= 1'b0;
    end else begin
      fft_valid   <= 1'b0;
      frame_start <= 1'b0;
      flush_done  <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            state       <= S_RUN;
            beat_cnt    <= CNT_W'(1);
            fft_valid   <= 1'b1;
            beat_idx    <= '0;
            frame_start <= 1'b1;
          end else if (flush) begin
            state <= S_DRAIN;
          end
        end
        S_RUN: begin
          // a missing source beat only stalls the count; the underrun flag records it
          if (accept) begin
            fft_valid <= 1'b1;
            beat_idx  <= beat_cnt;
            if (beat_cnt == LAST_BEAT) begin
              state    <= S_GAP;
              beat_cnt <= '0;
              gap_cnt  <= '0;
            end else begin
              beat_cnt <= beat_cnt + CNT_W'(1);
            end
          end
        end
        S_GAP: begin
          if (gap_cnt == GAP_LAST) begin
            gap_cnt <= '0;
            state   <= flush ? S_DRAIN : S_IDLE;
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end
        S_DRAIN: begin
          if (inflight == '0) begin
            flush_done <= 1'b1;
            state      <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Output side: count cbfp beats, retire frames, track frames in flight
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_cnt    <= '0;
      frame_done <= 1'b0;
      inflight   <= '0;
    end else begin
      frame_done <= out_last;
      if (out_beat) begin
        out_cnt <= out_last ? '0 : out_cnt + CNT_W'(1);
      end
      // a start and a retirement in the same cycle cancel out
      unique case ({start, out_last})
        2'b10:   inflight <= inflight + IF_W'(1);
        2'b01:   inflight <= inflight - IF_W'(1);
        default: inflight <= inflight;
      endcase
    end
  end

  // Sticky error flags; a new error in the clear cycle keeps the flag set
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      err_underrun <= 1'b0;
      err_overflow <= 1'b0;
    end else begin
      err_underrun <= underrun_evt | (err_underrun & ~clr_err);
      err_overflow <= overflow_evt | (err_overflow & ~clr_err);
    end
  end

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Testbench for fft_frame_ctrl: directed frames, output drains, underrun,
// flush, overflow and asynchronous reset. Issue beats and frame completions
// go through expected queues checked by an independent monitor.
module tb_fft_frame_ctrl;

  localparam int CNT_W = 5;
  localparam int IF_W  = 3;

  logic             clk;
  logic             rstn;
  logic             en;
  logic             flush;
  logic             clr_err;
  logic             src_valid;
  logic             src_ready;
  logic             fft_valid;
  logic [CNT_W-1:0] beat_idx;
  logic             frame_start;
  logic             pipe_out_valid;
  logic             frame_done;
  logic [IF_W-1:0]  inflight;
  logic             busy;
  logic             flush_done;
  logic             err_underrun;
  logic             err_overflow;
  logic [1:0]       fsm_state;

  int          vec_cnt = 0;
  int          miss_cnt = 0;
  int unsigned cyc = 0;

  // {expected cycle, frame_start, beat_idx}
  logic [37:0] exp_q[$];
  // {expected cycle, inflight after retirement}
  logic [34:0] done_q[$];

  fft_frame_ctrl dut (
    .clk            (clk),
    .rstn           (rstn),
    .en             (en),
    .flush          (flush),
    .clr_err        (clr_err),
    .src_valid      (src_valid),
    .src_ready      (src_ready),
    .fft_valid      (fft_valid),
    .beat_idx       (beat_idx),
    .frame_start    (frame_start),
    .pipe_out_valid (pipe_out_valid),
    .frame_done     (frame_done),
    .inflight       (inflight),
    .busy           (busy),
    .flush_done     (flush_done),
    .err_underrun   (err_underrun),
    .err_overflow   (err_overflow),
    .fsm_state      (fsm_state)
  );

  // clock and cycle stamp
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // drive one source beat; expectation pushed when the transfer is certain
  task automatic send_beat(input logic [4:0] idx);
    int t;
    t = 0;
    src_valid = 1'b1;
    #1;
    while (!src_ready && t < 300) begin
      @(negedge clk);
      #1;
      t++;
    end
    if (!src_ready) begin
      check("src_ready_timeout", {31'b0, src_ready}, 1);
    end else begin
      exp_q.push_back({cyc + 32'd1, (idx == 5'd0), idx});
    end
    @(negedge clk);
  endtask

  // one full frame; hole_at >= 0 drops src_valid for 3 cycles before that beat
  task automatic send_frame(input int hole_at);
    for (int b = 0; b < 32; b++) begin
      if (b == hole_at) begin
        src_valid = 1'b0;
        repeat (3) @(negedge clk);
      end
      send_beat(b[4:0]);
    end
  endtask

  // 32 cbfp output beats retiring one frame; called on a falling edge
  task automatic drain_frame(input logic [2:0] exp_if);
    for (int i = 0; i < 32; i++) begin
      pipe_out_valid = 1'b1;
      if (i == 31) done_q.push_back({cyc + 32'd1, exp_if});
      @(negedge clk);
    end
    pipe_out_valid = 1'b0;
  endtask

  // monitor: pop and compare whenever the DUT presents an issue beat or a frame completion
  initial begin : monitor
    logic [37:0] e;
    logic [34:0] d;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        exp_q.delete();
        done_q.delete();
      end else begin
        if (fft_valid) begin
          if (exp_q.size() == 0) begin
            check("fft_valid_unexpected", {31'b0, fft_valid}, 0);
          end else begin
            e = exp_q.pop_front();
            check("beat_idx", {27'b0, beat_idx}, {27'b0, e[4:0]});
            check("frame_start", {31'b0, frame_start}, {31'b0, e[5]});
            check("beat_cycle", cyc, e[37:6]);
          end
        end else if (frame_start) begin
          check("frame_start_alone", {31'b0, frame_start}, 0);
        end
        if (frame_done) begin
          if (done_q.size() == 0) begin
            check("frame_done_unexpected", {31'b0, frame_done}, 0);
          end else begin
            d = done_q.pop_front();
            check("done_inflight", {29'b0, inflight}, {29'b0, d[2:0]});
            check("done_cycle", cyc, d[34:3]);
          end
        end
      end
    end
  end

  // watchdog
  initial begin
    #400000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  // directed stimulus
  initial begin
    rstn = 1'b0; en = 1'b0; flush = 1'b0; clr_err = 1'b0;
    src_valid = 1'b0; pipe_out_valid = 1'b0;

    // reset values
    repeat (3) @(negedge clk);
    #1;
    check("rst_src_ready", {31'b0, src_ready}, 0);
    check("rst_fft_valid", {31'b0, fft_valid}, 0);
    check("rst_beat_idx", {27'b0, beat_idx}, 0);
    check("rst_frame_start", {31'b0, frame_start}, 0);
    check("rst_frame_done", {31'b0, frame_done}, 0);
    check("rst_inflight", {29'b0, inflight}, 0);
    check("rst_busy", {31'b0, busy}, 0);
    check("rst_flush_done", {31'b0, flush_done}, 0);
    check("rst_err_underrun", {31'b0, err_underrun}, 0);
    check("rst_err_overflow", {31'b0, err_overflow}, 0);
    @(negedge clk);
    rstn = 1'b1;
    en = 1'b1;
    repeat (2) @(negedge clk);

    // single frame issue
    send_frame(-1);
    src_valid = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("t1_inflight", {29'b0, inflight}, 1);
    check("t1_busy", {31'b0, busy}, 1);
    check("t1_err_underrun", {31'b0, err_underrun}, 0);

    // retire that frame
    @(negedge clk);
    drain_frame(3'd0);
    repeat (2) @(negedge clk);
    #1;
    check("t2_inflight", {29'b0, inflight}, 0);
    check("t2_busy", {31'b0, busy}, 0);
    check("t2_state_idle", {30'b0, fsm_state}, 0);

    // fill to MAX_INFLIGHT with 2-cycle gaps
    @(negedge clk);
    send_frame(-1);
    src_valid = 1'b0;
    #1;
    check("t3_gap_ready_a", {31'b0, src_ready}, 0);
    @(negedge clk);
    #1;
    check("t3_gap_ready_b", {31'b0, src_ready}, 0);
    @(negedge clk);
    #1;
    check("t3_after_gap_ready", {31'b0, src_ready}, 1);
    send_frame(-1);
    send_frame(-1);
    send_frame(-1);
    repeat (6) @(negedge clk);
    #1;
    check("t3_full_ready", {31'b0, src_ready}, 0);
    check("t3_full_inflight", {29'b0, inflight}, 4);
    src_valid = 1'b0;
    @(negedge clk);
    drain_frame(3'd3);
    #1;
    check("t3_ready_after_drain", {31'b0, src_ready}, 1);
    @(negedge clk);
    drain_frame(3'd2);
    drain_frame(3'd1);
    drain_frame(3'd0);

    // underrun at beat 10 for 3 cycles
    send_frame(10);
    src_valid = 1'b0;
    #1;
    check("t4_err_underrun", {31'b0, err_underrun}, 1);
    @(negedge clk);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    #1;
    check("t4_underrun_cleared", {31'b0, err_underrun}, 0);
    check("t4_inflight", {29'b0, inflight}, 1);

    // flush at beat 5 with a second frame in flight
    @(negedge clk);
    for (int b = 0; b < 5; b++) send_beat(b[4:0]);
    flush = 1'b1;
    for (int b = 5; b < 32; b++) send_beat(b[4:0]);
    repeat (4) @(negedge clk);
    #1;
    check("t5_state_drain", {30'b0, fsm_state}, 3);
    check("t5_inflight", {29'b0, inflight}, 2);
    check("t5_ready_drain", {31'b0, src_ready}, 0);
    src_valid = 1'b0;
    @(negedge clk);
    drain_frame(3'd1);
    #1;
    check("t5_flush_done_early", {31'b0, flush_done}, 0);
    @(negedge clk);
    drain_frame(3'd0);
    #1;
    check("t5_flush_done_zero", {31'b0, flush_done}, 0);
    @(negedge clk);
    #1;
    check("t5_flush_done_pulse", {31'b0, flush_done}, 1);
    flush = 1'b0;
    @(negedge clk);
    #1;
    check("t5_flush_done_end", {31'b0, flush_done}, 0);
    check("t5_state_idle", {30'b0, fsm_state}, 0);
    check("t5_busy", {31'b0, busy}, 0);

    // overflow, error-wins-over-clear, then clear
    @(negedge clk);
    pipe_out_valid = 1'b1;
    @(negedge clk);
    pipe_out_valid = 1'b0;
    #1;
    check("t6_err_overflow", {31'b0, err_overflow}, 1);
    check("t6_inflight", {29'b0, inflight}, 0);
    @(negedge clk);
    pipe_out_valid = 1'b1;
    clr_err = 1'b1;
    @(negedge clk);
    pipe_out_valid = 1'b0;
    clr_err = 1'b0;
    #1;
    check("t6_err_wins", {31'b0, err_overflow}, 1);
    @(negedge clk);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    #1;
    check("t6_overflow_cleared", {31'b0, err_overflow}, 0);

    // asynchronous reset in the middle of a frame
    @(negedge clk);
    for (int b = 0; b < 8; b++) send_beat(b[4:0]);
    #2;
    rstn = 1'b0;
    src_valid = 1'b0;
    #1;
    check("t6_rst_fft_valid", {31'b0, fft_valid}, 0);
    check("t6_rst_src_ready", {31'b0, src_ready}, 0);
    check("t6_rst_inflight", {29'b0, inflight}, 0);
    check("t6_rst_busy", {31'b0, busy}, 0);
    check("t6_rst_beat_idx", {27'b0, beat_idx}, 0);
    check("t6_rst_state", {30'b0, fsm_state}, 0);
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    repeat (40) @(negedge clk);
    #1;
    check("t6_post_rst_inflight", {29'b0, inflight}, 0);
    check("t6_post_rst_busy", {31'b0, busy}, 0);

    check("exp_q_empty", exp_q.size(), 0);
    check("done_q_empty", done_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
